imem_boot_loader: RTL and testbench

- Upstream stage of the single-cycle RISC-V core.
- Receives a little-endian byte stream: a 4-byte header holding word count N, followed by N little-endian 32-bit instruction words.
- Writes each assembled word into the instruction memory write port, starting at word address 0.
- Holds the core in reset (core_rst_n low) until the load completes, then releases it.

---
 rtl/imem_boot_pkg.sv | 24 ++
 rtl/imem_boot_loader_byte_word_assembler.sv | 38 +++
 rtl/imem_boot_loader.sv | 149 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    LOAD = 3'd1,
    CSUM = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } boot_state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  // States in which the loader takes bytes from the stream.
  function automatic logic accepts_bytes(input boot_state_e st);
    case (st)
      HDR, LOAD, CSUM: accepts_bytes = 1'b1;
      default:         accepts_bytes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Little-endian byte-to-word assembler shared by the header and payload phases.
// word_valid/word are combinational so the caller can act on the final byte's edge.
module byte_word_assembler
  import imem_boot_pkg::*;
#(
  parameter int NBYTES = WORD_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  word_valid,
  output logic [8*NBYTES-1:0]   word
);

  localparam int IDX_W  = $clog2(NBYTES);
  localparam int PART_W = 8 * (NBYTES - 1);

  logic [IDX_W-1:0]  idx_r;
  logic [PART_W-1:0] part_r;
  logic              last_s;

  assign last_s     = (idx_r == IDX_W'(NBYTES - 1));
  assign word_valid = byte_valid && last_s;
  assign word       = {byte_data, part_r};

  // Byte index and right-shifting partial word (earliest byte ends up lowest).
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r  <= '0;
      part_r <= '0;
    end else if (byte_valid) begin
      idx_r  <= last_s ? '0 : idx_r + IDX_W'(1);
      part_r <= {byte_data, part_r[PART_W-1:8]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: byte stream (count header + LE words) into IMEM, then releases the core.
// Optional trailing XOR checksum byte when IMEM_BOOT_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int          GROUP_BYTES = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;
  localparam logic [32:0] N_MAX       = 33'd1 << ADDR_W;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  localparam boot_state_e AFTER_DATA = CSUM;
`else
  localparam boot_state_e AFTER_DATA = FIN;
`endif

  boot_state_e             state_r, state_n;
  logic                    accept_s, asm_valid_s, word_valid_s;
  logic [8*GROUP_BYTES-1:0] word_s;
  logic                    hdr_oversize_s, hdr_zero_s, last_word_s, csum_ok_s;
  logic [ADDR_W:0]         n_r, word_cnt_r, word_cnt_inc_s;
  logic                    in_ready_r, imem_we_r, core_rst_n_r, done_r, error_r;
  logic [ADDR_W-1:0]       imem_addr_r;
  logic [31:0]             imem_wdata_r;

  assign accept_s    = in_valid && in_ready_r;
  assign asm_valid_s = accept_s && ((state_r == HDR) || (state_r == LOAD));

  byte_word_assembler #(.NBYTES(GROUP_BYTES)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (asm_valid_s),
    .byte_data  (in_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // N is unsigned 32-bit; anything above capacity is rejected, so storing ADDR_W+1 bits is exact.
  assign hdr_oversize_s = ({1'b0, word_s} > N_MAX);
  assign hdr_zero_s     = (word_s == 32'd0);
  assign word_cnt_inc_s = word_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word_s    = (word_cnt_inc_s == n_r);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum_r;

  // Running XOR over every accepted header and payload byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_r <= 8'd0;
    end else if (asm_valid_s) begin
      csum_r <= csum_r ^ in_data;
    end
  end

  assign csum_ok_s = (in_data == csum_r);
`else
  assign csum_ok_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HDR;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      HDR: begin
        if (word_valid_s) begin
          if (hdr_oversize_s) state_n = ERR;
          else if (hdr_zero_s) state_n = AFTER_DATA;
          else state_n = LOAD;
        end else begin
          state_n = state_r;
        end
      end
      LOAD: begin
        if (word_valid_s && last_word_s) state_n = AFTER_DATA;
        else state_n = state_r;
      end
      CSUM: begin
        if (accept_s) state_n = csum_ok_s ? FIN : ERR;
        else state_n = state_r;
      end
      FIN:     state_n = DONE;
      DONE:    state_n = DONE;
      ERR:     state_n = ERR;
      default: state_n = ERR;
    endcase
  end

  // Registered outputs and load bookkeeping; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r          <= '0;
      word_cnt_r   <= '0;
      in_ready_r   <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
      core_rst_n_r <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      in_ready_r   <= accepts_bytes(state_n);
      imem_we_r    <= (state_r == LOAD) && word_valid_s;
      core_rst_n_r <= (state_n == DONE);
      done_r       <= (state_n == DONE);
      error_r      <= (state_n == ERR);
      if ((state_r == HDR) && word_valid_s) begin
        n_r <= word_s[ADDR_W:0];
      end
      if ((state_r == LOAD) && word_valid_s) begin
        imem_addr_r  <= word_cnt_r[ADDR_W-1:0];
        imem_wdata_r <= word_s[31:0];
        word_cnt_r   <= word_cnt_inc_s;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign imem_we      = imem_we_r;
  assign imem_addr    = imem_addr_r;
  assign imem_wdata   = imem_wdata_r;
  assign core_rst_n   = core_rst_n_r;
  assign done         = done_r;
  assign error        = error_r;
  assign words_loaded = word_cnt_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (ADDR_W=4): vector table plus corner sequences,
// with an IMEM write scoreboard. Adds the checksum byte when IMEM_BOOT_LOADER_CHECKSUM_EN is set.
module tb_imem_boot_loader;

  localparam int ADDR_W = 4;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst_n   (core_rst_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] n;
    int          send_words;
    bit          gaps;
    logic [31:0] seed;
    bit          exp_done;
    bit          exp_err;
    int          exp_wl;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  wr_t  exp_q[$];
  int   pulse_cyc[$];
  wr_t  mon_w;
  logic [7:0] xor_acc;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    check("done_and_error", 32'(done & error), 32'd0);
    if (imem_we === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_w = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(mon_w.addr));
        check("write_data", imem_wdata, mon_w.data);
        check("wl_at_write", 32'(words_loaded), 32'(mon_w.addr) + 32'd1);
      end
    end
  end

  function automatic logic [31:0] word_of(input int k, input logic [31:0] seed);
    if (seed == 32'd0) return (k == 0) ? 32'h0010_0013 : (k == 1) ? 32'h0050_0193 : 32'd0;
    else return seed ^ (32'(k) * 32'h9E37_79B1);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got;
    int wait_n;
    if (gaps) begin
      int g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    got      = 1'b0;
    wait_n   = 0;
    while (!got && wait_n < 50) begin
      got = in_ready;
      @(negedge clk);
      wait_n++;
    end
    check("byte_accepted", 32'(got), 32'd1);
    xor_acc = xor_acc ^ b;
  endtask

  task automatic run_load(input logic [31:0] n, input int send_words, input bit gaps,
                          input logic [31:0] seed);
    logic [31:0] w;
    wr_t e;
    xor_acc = 8'd0;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gaps);
    for (int k = 0; k < send_words; k++) begin
      w      = word_of(k, seed);
      e.addr = k[ADDR_W-1:0];
      e.data = w;
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    if (n <= 32'(CAP)) begin
      logic [7:0] c = xor_acc;
      send_byte(c, gaps);
    end
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", 32'(done | error), 32'd1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'd0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [31:0] w;
    wr_t e;

    vecs[0] = '{"two_word",      32'd2,           2,  1'b0, 32'd0,          1'b1, 1'b0, 2};
    vecs[1] = '{"two_word_gaps", 32'd2,           2,  1'b1, 32'd0,          1'b1, 1'b0, 2};
    vecs[2] = '{"three_gaps",    32'd3,           3,  1'b1, 32'h1234_5678,  1'b1, 1'b0, 3};
    vecs[3] = '{"full_cap",      32'(CAP),        CAP, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0, CAP};
    vecs[4] = '{"zero_words",    32'd0,           0,  1'b1, 32'd0,          1'b1, 1'b0, 0};
    vecs[5] = '{"over_by_one",   32'(CAP + 1),    0,  1'b0, 32'd0,          1'b0, 1'b1, 0};
    vecs[6] = '{"over_huge",     32'hFFFF_FFFF,   0,  1'b1, 32'd0,          1'b0, 1'b1, 0};
    vecs[7] = '{"over_high_bits",32'h0001_0001,   0,  1'b0, 32'd0,          1'b0, 1'b1, 0};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      run_load(vecs[v].n, vecs[v].send_words, vecs[v].gaps, vecs[v].seed);
      wait_end();
      check({vecs[v].name, "_done"}, 32'(done), 32'(vecs[v].exp_done));
      check({vecs[v].name, "_error"}, 32'(error), 32'(vecs[v].exp_err));
      check({vecs[v].name, "_core_rst_n"}, 32'(core_rst_n), 32'(vecs[v].exp_done));
      check({vecs[v].name, "_in_ready"}, 32'(in_ready), 32'd0);
      check({vecs[v].name, "_words_loaded"}, 32'(words_loaded), 32'(vecs[v].exp_wl));
      in_valid = 1'b1;
      in_data  = 8'h5A;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check({vecs[v].name, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    end

    // Back-to-back two-word load: write spacing and the single FIN cycle.
    do_reset();
    pulse_cyc.delete();
    t0 = cyc;
    run_load(32'd2, 2, 1'b0, 32'd0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    check("b2b_cycles", 32'(cyc - t0), 32'd13);
`else
    check("b2b_cycles", 32'(cyc - t0), 32'd12);
    check("b2b_last_we", 32'(imem_we), 32'd1);
`endif
    check("fin_in_ready", 32'(in_ready), 32'd0);
    check("fin_done", 32'(done), 32'd0);
    check("fin_core_rst_n", 32'(core_rst_n), 32'd0);
    @(negedge clk);
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_core_rst_n", 32'(core_rst_n), 32'd1);
    check("b2b_words_loaded", 32'(words_loaded), 32'd2);
    check("b2b_pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) check("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd4);

    // N=0: FIN right after the header, DONE the cycle after, no writes.
    do_reset();
    pulse_cyc.delete();
    run_load(32'd0, 0, 1'b0, 32'd0);
    check("n0_fin_done", 32'(done), 32'd0);
    check("n0_fin_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("n0_done", 32'(done), 32'd1);
    check("n0_core_rst_n", 32'(core_rst_n), 32'd1);
    check("n0_no_writes", 32'(pulse_cyc.size()), 32'd0);

    // Reset after six payload bytes, then a fresh one-word load.
    do_reset();
    xor_acc = 8'd0;
    for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 2 : 0), 1'b0);
    w      = 32'hAABB_CCDD;
    e.addr = '0;
    e.data = w;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    do_reset();
    run_load(32'd1, 1, 1'b1, 32'hDEAD_BEEF);
    wait_end();
    check("midrst_done", 32'(done), 32'd1);
    check("midrst_words_loaded", 32'(words_loaded), 32'd1);
    check("midrst_last_wdata", imem_wdata, 32'hDEAD_BEEF);
    check("midrst_drained", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    // Wrong checksum byte aborts the load.
    do_reset();
    xor_acc = 8'd0;
    for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 1 : 0), 1'b0);
    w      = 32'h0010_0013;
    e.addr = '0;
    e.data = w;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
    check("csum_value", 32'(xor_acc), 32'h02);
    send_byte(8'h03, 1'b0);
    in_valid = 1'b0;
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_done", 32'(done), 32'd0);
    check("csum_bad_in_ready", 32'(in_ready), 32'd0);
    check("csum_bad_core_rst_n", 32'(core_rst_n), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
